oflow_prev_feature_fetch: RTL
=============================

Name: oflow_prev_feature_fetch

Overview:
Upstream feeder for oflow_registration. On start_fetch it reads the previous-frame feature lines from the MEM buffer, two objects per line. It presents each pair on data_to_similarity_metric_0/1 to the two similarity-metric PEs and advances on control_for_read_new_line. After the last line is consumed it pulses done_read.

Parameters:
DATA_W, `DATA_TO_PE_WIDTH, width of one object record {cm, position, w, h, color1, color2, d_history, id}
ADDR_W, 6, MEM buffer line address width
CNT_W, 7, width of object count (max 2^CNT_W-1 objects)

Ports:
clk  in  1  system clock, rising edge
reset_N  in  1  synchronous reset, active-high (name kept per codebase)
start_fetch  in  1  one-cycle request to fetch the previous frame
num_of_prev_objects  in  CNT_W  object count, sampled with start_fetch
base_addr  in  ADDR_W  first line address, sampled with start_fetch
mem_rd_en  out  1  read strobe to the MEM buffer
mem_addr  out  ADDR_W  read line address
mem_rd_data  in  2*DATA_W  line data: [2*DATA_W-1:DATA_W] = object 0, [DATA_W-1:0] = object 1; valid the cycle after mem_rd_en
control_for_read_new_line  in  1  from registration: both metrics finished with the current pair
data_to_similarity_metric_0  out  DATA_W  object record for PE0
data_to_similarity_metric_1  out  DATA_W  object record for PE1
pe_valid_0  out  1  data_to_similarity_metric_0 holds a real object
pe_valid_1  out  1  data_to_similarity_metric_1 holds a real object; 0 for the odd tail
done_read  out  1  one-cycle pulse after the last pair is consumed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0. Reset asserted mid-fetch aborts the fetch immediately and produces no done_read.
- Internal state: lines_total = ceil(n/2) = (n+1)>>1, held in CNT_W bits. line_idx counts from 0. mem_addr = base_addr + line_idx, modulo 2^ADDR_W, so the address wraps.
- FSM states: IDLE, RD, WAIT, PRESENT, DONE.
- IDLE:
  - start_fetch=1 and n>0: latch n and base_addr, line_idx=0, go to RD.
  - start_fetch=1 and n=0: go to DONE.
- RD: mem_rd_en=1 for exactly one cycle, mem_addr valid. Go to WAIT.
- WAIT: capture mem_rd_data into both data outputs at the closing edge.
  - pe_valid_0=1.
  - pe_valid_1=0 only if this is the last line and n is odd; otherwise 1.
  - Go to PRESENT.
- PRESENT: data and valids are held stable until control_for_read_new_line=1 is sampled.
  - If line_idx+1 < lines_total: line_idx++, valids drop to 0, data outputs hold their old values, go to RD.
  - Otherwise: valids drop to 0, go to DONE.
- DONE: done_read=1 for one cycle, then go to IDLE. busy=0 from the next cycle.
- Latency: start_fetch sampled at edge E0 gives mem_rd_en during E0–E1 and pe_valid high from E2. Each consume-to-next-valid turnaround is 3 cycles (PRESENT→RD→WAIT→PRESENT). For n=0, done_read is high during E1–E2.
- control_for_read_new_line outside PRESENT is ignored. It is not queued.
- start_fetch while busy=1 is ignored. Latched n and base_addr are unchanged.
- Only one mem read is outstanding at any time. mem_rd_en is never high for two consecutive cycles.
- The id field is passed through unmodified. The block does no field decoding.

Test Plan:
1. n=4, base_addr=0, lines L0={A,B}, L1={C,D}; pulse control once per PRESENT.
   - Reads at addr 0 then 1.
   - Outputs show A/B then C/D, with pe_valid_0=pe_valid_1=1 for both pairs.
   - done_read pulses exactly once, 1 cycle after the second control pulse.
2. n=3: second pair shows pe_valid_0=1, pe_valid_1=0, and only 2 reads are issued.
3. n=0: no mem_rd_en, pe_valid never high, done_read high in the cycle after start_fetch, busy for 2 cycles.
4. base_addr=63, ADDR_W=6, n=4: mem_addr sequence is 63, 0 (wrap-around).
5. Ignored inputs:
   - start_fetch again while in PRESENT: latched n unchanged, same read count.
   - control_for_read_new_line held high during RD/WAIT: no skipped line. The line advances only on the PRESENT sample.
6. reset_N=1 asserted while in PRESENT with n=6:
   - Next cycle all outputs are 0 and FSM is IDLE; no done_read.
   - A subsequent start_fetch with n=2 completes normally.

Source files
------------

// File: rtl/oflow_prev_feature_fetch.sv
// Previous-frame feature fetcher: reads object pairs from the MEM buffer
// and presents them to the two similarity-metric PEs, one line at a time.
module oflow_prev_feature_fetch #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 7
) (
   input  logic                clk,
   input  logic                reset_N,
   input  logic                start_fetch,
   input  logic [CNT_W-1:0]    num_of_prev_objects,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [2*DATA_W-1:0] mem_rd_data,
   input  logic                control_for_read_new_line,
   output logic [DATA_W-1:0]   data_to_similarity_metric_0,
   output logic [DATA_W-1:0]   data_to_similarity_metric_1,
   output logic                pe_valid_0,
   output logic                pe_valid_1,
   output logic                done_read,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  line_idx;
   logic [CNT_W-1:0]  lines_total;
   logic              odd_q;
   logic              done_arm;
   logic [CNT_W:0]    n_inc;
   logic [CNT_W:0]    idx_inc;
   logic              more_lines;
   logic              start_ok;

   // n+1 needs one extra bit so ceil(n/2) is exact at the top of the range
   assign n_inc      = {1'b0, num_of_prev_objects} + 1'b1;
   assign idx_inc    = {1'b0, line_idx} + 1'b1;
   assign more_lines = idx_inc < {1'b0, lines_total};
   assign start_ok   = start_fetch && (num_of_prev_objects != '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset_N) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start_fetch)
               state_nx = start_ok ? S_RD : S_DONE;
         end
         S_RD:   state_nx = S_WAIT;
         S_WAIT: state_nx = S_PRESENT;
         S_PRESENT: begin
            if (control_for_read_new_line)
               state_nx = more_lines ? S_RD : S_DONE;
         end
         S_DONE: begin
            if (done_arm) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      mem_rd_en = (state == S_RD);
      done_read = (state == S_DONE) && done_arm;
      busy      = (state != S_IDLE);
      mem_addr  = base_q + ADDR_W'(line_idx);
   end

   // Fetch context, line counter and the presented PE pair
   always_ff @(posedge clk) begin
      if (reset_N) begin
         base_q      <= '0;
         line_idx    <= '0;
         lines_total <= '0;
         odd_q       <= 1'b0;
         done_arm    <= 1'b0;
         pe_valid_0  <= 1'b0;
         pe_valid_1  <= 1'b0;
         data_to_similarity_metric_0 <= '0;
         data_to_similarity_metric_1 <= '0;
      end else begin
         // DONE spans two cycles; the pulse is raised in the second one
         done_arm <= (state == S_DONE) ? ~done_arm : 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  base_q      <= base_addr;
                  line_idx    <= '0;
                  lines_total <= n_inc[CNT_W:1];
                  odd_q       <= num_of_prev_objects[0];
               end
            end
            S_WAIT: begin
               data_to_similarity_metric_0 <= mem_rd_data[2*DATA_W-1:DATA_W];
               data_to_similarity_metric_1 <= mem_rd_data[DATA_W-1:0];
               pe_valid_0 <= 1'b1;
               pe_valid_1 <= ~(~more_lines & odd_q);
            end
            S_PRESENT: begin
               if (control_for_read_new_line) begin
                  pe_valid_0 <= 1'b0;
                  pe_valid_1 <= 1'b0;
                  if (more_lines) line_idx <= idx_inc[CNT_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
